mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the 5-stage pipeline, fed directly by the EX/MEM register.
//  Resolves beq (pc_src) and performs data-memory loads/stores with a configurable access latency.
//  Stalls upstream while an access is in flight and owns the MEM/WB register that feeds write-back.
// PARAMETERS
//  MEM_DEPTH    256  data-memory size in 32-bit words (power of 2)
//  MEM_LATENCY  1    cycles per load/store access (>=1); 1 = no stall
// PORTS
//  clock               in   1   pipeline clock; all state updates on the falling edge
//  reset               in   1   asynchronous, active-low (0 = reset)
//  mem_to_reg_in       in   1   WB ctrl from EX/MEM
//  reg_write_in        in   1   WB ctrl from EX/MEM
//  mem_read_in         in   1   load request
//  mem_write_in        in   1   store request
//  beq_instruction_in  in   1   instruction is beq
//  flag_beq_in         in   1   ALU equality flag
//  alu_result_in       in   32  byte address / ALU result
//  mux2_result_in      in   32  store data
//  reg_rd_in           in   5   destination register
//  pc_src              out  1   branch taken, combinational
//  stall               out  1   freeze PC, IF/ID, ID/EX and EX/MEM; combinational from state
//  mem_to_reg_out      out  1   MEM/WB ctrl
//  reg_write_out       out  1   MEM/WB ctrl
//  read_data_out       out  32  loaded word
//  alu_result_out      out  32  forwarded ALU result
//  reg_rd_out          out  5   forwarded destination
// BEHAVIOUR
//  - Reset (async, reset==0): all MEM/WB outputs 0; FSM -> IDLE; counter 0; stall 0.
//    Memory contents untouched. An in-flight access is aborted and its store discarded.
//  - pc_src = beq_instruction_in & flag_beq_in. It is not gated by stall.
//  - Word index = alu_result_in[log2(MEM_DEPTH)+1:2]; bits [1:0] ignored.
//    Addresses beyond the depth wrap (upper bits dropped).
//  - FSM states: IDLE, BUSY.
//    * IDLE, no access, or MEM_LATENCY==1: MEM/WB latches inputs on this falling edge.
//      A store writes the array on the same edge; a load captures array[idx] into read_data_out.
//    * IDLE with an access and MEM_LATENCY>1: -> BUSY, counter = MEM_LATENCY-1, stall=1.
//      MEM/WB latches a bubble (all ctrl 0, data 0).
//    * BUSY: counter decrements each edge. stall=1 while counter!=0.
//      On the edge with counter==1, perform the access, latch the real MEM/WB values, -> IDLE.
//      Load latency is therefore MEM_LATENCY edges.
//    * Upstream holds its inputs stable while stall=1. Inputs are sampled only on the completing edge.
//  - read and write both asserted: the store wins and read_data_out = 0.
//  - Non-load instructions: read_data_out = 0.
//  - Counter width = $clog2(MEM_LATENCY+1). No wrap is reachable.
// CONFIGURATION
//  MEM_STAGE_ALIGN_CHECK_EN defined:
//    - Adds output misalign_out (1 bit, reset 0), registered with MEM/WB.
//    - Set when an access has alu_result_in[1:0]!=0.
//    - That store is suppressed and that load returns 0; reg_write_out is still forwarded.
//  Not defined: no port, bits [1:0] silently ignored.
// STRUCTURE
//  pipeline_pkg: DATA_W=32, REG_ADDR_W=5, mem_state_t {IDLE,BUSY}.
//  Sub-module data_memory: MEM_DEPTH x 32 array with a negedge write port and a combinational read port.
//  FSM, counter and MEM/WB register live in mem_stage.
// TESTING
//  1 MEM_LATENCY=1: store 0xDEADBEEF @0x10, then load @0x10 with rd=5
//    -> read_data_out=0xDEADBEEF, reg_rd_out=5, stall never 1.
//  2 beq_instruction_in=1, flag_beq_in=1 -> pc_src=1 same cycle.
//    With flag_beq_in=0 -> pc_src=0.
//  3 MEM_LATENCY=3: load @0x20 holding 0x12345678
//    -> stall=1 for 2 edges, bubbles in MEM/WB, then read_data_out=0x12345678 and stall=0.
//  4 MEM_DEPTH=256: store 0xA5 @0x400 -> load @0x000 returns 0xA5 (wrap).
//  5 MEM_LATENCY=3: store issued, reset=0 after 1 edge
//    -> outputs 0, stall 0, target word unchanged.
//  6 ALIGN_CHECK_EN: store 0x1 @0x13 -> misalign_out=1, memory unchanged.
//    Without the macro the word @0x10 is written.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline widths and the memory-stage FSM state type.
package pipeline_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: falling-edge write port, combinational read port.
module data_memory
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(negedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: beq resolution, multi-cycle data-memory access FSM and the MEM/WB register.
// Optional MEM_STAGE_ALIGN_CHECK_EN adds misalign_out and suppresses misaligned accesses.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  beq_instruction_in,
  input  logic                  flag_beq_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     mux2_result_in,
  input  logic [REG_ADDR_W-1:0] reg_rd_in,
  output logic                  pc_src,
  output logic                  stall,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [DATA_W-1:0]     alu_result_out,
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  output logic                  misalign_out,
`endif
  output logic [REG_ADDR_W-1:0] reg_rd_out
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  mem_state_t              state_q;
  logic [CW-1:0]           cnt_q;
  logic                    mem_to_reg_q;
  logic                    reg_write_q;
  logic [DATA_W-1:0]       read_data_q;
  logic [DATA_W-1:0]       alu_result_q;
  logic [REG_ADDR_W-1:0]   reg_rd_q;
  logic                    misalign_q;

  logic                    access;
  logic                    misalign;
  logic                    complete;
  logic                    load_ok;
  logic                    mem_we;
  logic [AW-1:0]           idx;
  logic [DATA_W-1:0]       mem_rdata;

  assign access = mem_read_in | mem_write_in;
  assign idx    = alu_result_in[AW+1:2];

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misalign = access & (alu_result_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // The access happens on exactly one edge: immediately when single-cycle, else on the last BUSY edge.
  assign complete = (state_q == IDLE) ? (!access || (MEM_LATENCY == 1))
                                      : (cnt_q == CW'(1));
  assign load_ok  = mem_read_in & ~mem_write_in & ~misalign;
  assign mem_we   = complete & mem_write_in & ~misalign & reset;

  assign pc_src = beq_instruction_in & flag_beq_in;
  assign stall  = (state_q == BUSY) && (cnt_q != '0);

  data_memory #(
    .DEPTH (MEM_DEPTH)
  ) u_data_memory (
    .clock (clock),
    .we    (mem_we),
    .addr  (idx),
    .wdata (mux2_result_in),
    .rdata (mem_rdata)
  );

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      reg_rd_q     <= '0;
      misalign_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access && (MEM_LATENCY > 1)) begin
            state_q <= BUSY;
            cnt_q   <= CW'(MEM_LATENCY - 1);
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (complete) begin
        mem_to_reg_q <= mem_to_reg_in;
        reg_write_q  <= reg_write_in;
        read_data_q  <= load_ok ? mem_rdata : '0;
        alu_result_q <= alu_result_in;
        reg_rd_q     <= reg_rd_in;
        misalign_q   <= misalign;
      end else begin
        mem_to_reg_q <= 1'b0;
        reg_write_q  <= 1'b0;
        read_data_q  <= '0;
        alu_result_q <= '0;
        reg_rd_q     <= '0;
        misalign_q   <= 1'b0;
      end
    end
  end

  assign mem_to_reg_out = mem_to_reg_q;
  assign reg_write_out  = reg_write_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign reg_rd_out     = reg_rd_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misalign_out   = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: single-cycle and 3-cycle instances, scoreboard of expected MEM/WB results.
module tb_mem_stage;

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic        rd_en;
    logic        wr_en;
    logic        beq;
    logic        flag;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  stim_t s1 = '0;
  stim_t s3 = '0;

  logic        pc1, stall1, m2r1, rw1, pc3, stall3, m2r3, rw3;
  logic [31:0] rdata1, alu1, rdata3, alu3;
  logic [4:0]  rd1, rd3;
  logic        mis1, mis3;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] model1 [256];
  logic [31:0] model3 [256];

  always #5 clk = ~clk;

  mem_stage #(.MEM_DEPTH(256), .MEM_LATENCY(1)) u_dut1 (
    .clock(clk), .reset(reset),
    .mem_to_reg_in(s1.m2r), .reg_write_in(s1.rw), .mem_read_in(s1.rd_en),
    .mem_write_in(s1.wr_en), .beq_instruction_in(s1.beq), .flag_beq_in(s1.flag),
    .alu_result_in(s1.alu), .mux2_result_in(s1.wdata), .reg_rd_in(s1.rd),
    .pc_src(pc1), .stall(stall1), .mem_to_reg_out(m2r1), .reg_write_out(rw1),
    .read_data_out(rdata1), .alu_result_out(alu1),
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    .misalign_out(mis1),
`endif
    .reg_rd_out(rd1)
  );

  mem_stage #(.MEM_DEPTH(256), .MEM_LATENCY(3)) u_dut3 (
    .clock(clk), .reset(reset),
    .mem_to_reg_in(s3.m2r), .reg_write_in(s3.rw), .mem_read_in(s3.rd_en),
    .mem_write_in(s3.wr_en), .beq_instruction_in(s3.beq), .flag_beq_in(s3.flag),
    .alu_result_in(s3.alu), .mux2_result_in(s3.wdata), .reg_rd_in(s3.rd),
    .pc_src(pc3), .stall(stall3), .mem_to_reg_out(m2r3), .reg_write_out(rw3),
    .read_data_out(rdata3), .alu_result_out(alu3),
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    .misalign_out(mis3),
`endif
    .reg_rd_out(rd3)
  );

`ifndef MEM_STAGE_ALIGN_CHECK_EN
  assign mis1 = 1'b0;
  assign mis3 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input bit use3);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "_rdata"}, use3 ? rdata3 : rdata1, e.rdata);
    check({e.tag, "_alu"},   use3 ? alu3   : alu1,   e.alu);
    check({e.tag, "_rd"},    32'(use3 ? rd3 : rd1),  32'(e.rd));
    check({e.tag, "_ctrl"},  32'(use3 ? {rw3, m2r3} : {rw1, m2r1}), 32'({e.rw, e.m2r}));
    if (ALIGN) check({e.tag, "_mis"}, 32'(use3 ? mis3 : mis1), 32'(e.mis));
    $display("txn %s: rdata=%h alu=%h rd=%0d", e.tag, use3 ? rdata3 : rdata1,
             use3 ? alu3 : alu1, use3 ? rd3 : rd1);
  endtask

  task automatic run_op(input bit use3, input string tag, input bit rd_en, input bit wr_en,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input bit rw, input bit m2r);
    stim_t s;
    exp_t  e;
    int    idx;
    int    nedges;
    bit    mis;
    s = '{m2r: m2r, rw: rw, rd_en: rd_en, wr_en: wr_en, beq: 1'b0, flag: 1'b0,
          alu: addr, wdata: wdata, rd: rd};
    idx = int'(addr[9:2]);
    mis = ALIGN && (rd_en || wr_en) && (addr[1:0] != 2'b00);
    e.tag = tag; e.alu = addr; e.rd = rd; e.rw = rw; e.m2r = m2r; e.mis = mis;
    e.rdata = (rd_en && !wr_en && !mis) ? (use3 ? model3[idx] : model1[idx]) : 32'h0;
    if (wr_en && !mis) begin
      if (use3) model3[idx] = wdata;
      else      model1[idx] = wdata;
    end
    @(posedge clk);
    if (use3) s3 = s;
    else      s1 = s;
    exp_q.push_back(e);
    nedges = (use3 && (rd_en || wr_en)) ? 3 : 1;
    for (int k = 1; k <= nedges; k++) begin
      @(negedge clk);
      #1;
      if (k < nedges) begin
        check({tag, "_stall_busy"}, 32'(stall3), 32'd1);
        check({tag, "_bubble_ctrl"}, 32'({rw3, m2r3}), 32'd0);
        check({tag, "_bubble_data"}, rdata3, 32'h0);
      end else begin
        check({tag, "_stall_done"}, 32'(use3 ? stall3 : stall1), 32'd0);
        pop_check(use3);
      end
    end
  endtask

  initial begin
    // Reset state of both instances.
    repeat (2) @(negedge clk);
    #1;
    check("rst_dut1_outs", {rdata1 | alu1, 27'(0), rd1}, 32'h0);
    check("rst_dut1_ctrl", 32'({stall1, rw1, m2r1, mis1}), 32'h0);
    check("rst_dut3_outs", {rdata3 | alu3, 27'(0), rd3}, 32'h0);
    check("rst_dut3_ctrl", 32'({stall3, rw3, m2r3, mis3}), 32'h0);
    @(posedge clk);
    reset = 1'b1;

    // Single-cycle latency: store then load.
    run_op(0, "t1_store", 0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
    run_op(0, "t1_load",  1, 0, 32'h10, 32'h0, 5'd5, 1, 1);

    // Branch resolution is combinational.
    @(posedge clk);
    s1 = '0; s1.beq = 1'b1; s1.flag = 1'b1;
    #1 check("t2_taken", 32'(pc1), 32'd1);
    s1.flag = 1'b0;
    #1 check("t2_flag0", 32'(pc1), 32'd0);
    s1.beq = 1'b0; s1.flag = 1'b1;
    #1 check("t2_nobeq", 32'(pc1), 32'd0);
    s1 = '0;

    // Address wrap, read+write collision, non-load forwarding.
    run_op(0, "t4_store_wrap", 0, 1, 32'h400, 32'hA5, 5'd0, 0, 0);
    run_op(0, "t4_load_zero",  1, 0, 32'h000, 32'h0, 5'd6, 1, 1);
    run_op(0, "rw_both",       1, 1, 32'h20, 32'h77, 5'd4, 1, 1);
    run_op(0, "rw_load",       1, 0, 32'h20, 32'h0, 5'd4, 1, 1);
    run_op(0, "alu_only",      0, 0, 32'h1234, 32'hFFFF, 5'd7, 1, 0);
    run_op(0, "t4_load_402",   1, 0, 32'h402, 32'h0, 5'd8, 1, 1);

    // Misaligned store, then read the containing word.
    run_op(0, "t6_store_mis", 0, 1, 32'h13, 32'h1, 5'd0, 1, 0);
    run_op(0, "t6_load",      1, 0, 32'h10, 32'h0, 5'd2, 1, 1);

    // Three-cycle latency instance.
    run_op(1, "t3_store", 0, 1, 32'h20, 32'h12345678, 5'd0, 0, 0);
    run_op(1, "t3_load",  1, 0, 32'h20, 32'h0, 5'd9, 1, 1);
    run_op(1, "t3_alu",   0, 0, 32'h55, 32'h0, 5'd3, 1, 0);

    // Abort an in-flight store with reset.
    run_op(1, "t5_prime", 0, 1, 32'h30, 32'h11111111, 5'd3, 1, 0);
    @(posedge clk);
    s3 = '{m2r: 1'b0, rw: 1'b0, rd_en: 1'b0, wr_en: 1'b1, beq: 1'b0, flag: 1'b0,
           alu: 32'h30, wdata: 32'h00000BAD, rd: 5'd0};
    @(negedge clk);
    #1 check("t5_inflight_stall", 32'(stall3), 32'd1);
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("t5_rst_stall", 32'(stall3), 32'd0);
    check("t5_rst_outs", {rdata3 | alu3, 27'(0), rd3}, 32'h0);
    check("t5_rst_ctrl", 32'({rw3, m2r3, mis3}), 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    s3 = '0;
    reset = 1'b1;
    run_op(1, "t5_load", 1, 0, 32'h30, 32'h0, 5'd1, 1, 1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
